// File: rtl/mem_axi_dbridge_pkg.sv
// ----------------------------------------------------------------------------
// mem_axi_dbridge_pkg
// Shared definitions for the MEM-stage data bridge: bus widths, AXI response
// codes and the bridge FSM state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package mem_axi_dbridge_pkg;

  // Default widths of the data-side bus (one 64-bit beat per request)
  localparam int BRIDGE_ADDR_W = 64;
  localparam int BRIDGE_DATA_W = 64;
  localparam int BRIDGE_STRB_W = BRIDGE_DATA_W / 8;

  // AXI response codes the bridge cares about; anything other than OKAY
  // is reported as a bus error
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bridge FSM states; encodings are fixed so they line up with the
  // values other tools in the lab expect to see on a debug probe
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_AR  = 3'd1,
    ST_RD_R   = 3'd2,
    ST_WR_AWW = 3'd3,
    ST_WR_B   = 3'd4,
    ST_DONE   = 3'd5
  } bridgeState_e;

endpackage

// File: rtl/mem_axi_dbridge.sv
// ----------------------------------------------------------------------------
// mem_axi_dbridge
// Data-side bridge between the MEM stage and an AXI4-Lite slave. Each load or
// store request becomes exactly one AXI4-Lite transaction; completion is
// reported with finish_o, which stays high until the pipeline advances so a
// frozen pipeline never re-issues the same access.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   req_addr_i         MEM-stage byte address (bus address is beat aligned)
//   req_wmask_i        byte write strobes for stores
//   req_wdata_i        lane-aligned store data
//   req_we_i/req_re_i  store / load request (store wins if both set)
//   pipe_adv_i         MEM stage advances; releases the DONE state
//   rdata_o            last full read beat
//   finish_o           request complete, rdata_o valid
//   bus_err_o          one-cycle pulse on a non-OKAY RRESP/BRESP
//   aw*/w*/b*/ar*/r*   AXI4-Lite master channels
// ----------------------------------------------------------------------------
module mem_axi_dbridge
  import mem_axi_dbridge_pkg::*;
#(
  parameter int ADDR_W = BRIDGE_ADDR_W,
  parameter int DATA_W = BRIDGE_DATA_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [STRB_W-1:0] req_wmask_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic              req_we_i,
  input  logic              req_re_i,
  input  logic              pipe_adv_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              finish_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  // Clears the byte offset so every access targets a whole 8-byte beat
  localparam logic [ADDR_W-1:0] BEAT_MASK = ~{{(ADDR_W-3){1'b0}}, 3'b111};

  bridgeState_e      state_q, state_d;
  logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
  logic [STRB_W-1:0] reqMask_q, reqMask_d;
  logic [DATA_W-1:0] reqData_q, reqData_d;
  logic              awDone_q, awDone_d;
  logic              wDone_q, wDone_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busErr_q, busErr_d;

  // State register. Reset mid-transaction simply drops back to IDLE; the
  // slave shares this reset so no half-finished handshake survives it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, AW/W completion flags, read beat and error pulse. The
  // request is frozen at the IDLE exit so later MEM-stage changes cannot
  // disturb an access already on the bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reqAddr_q <= '0;
      reqMask_q <= '0;
      reqData_q <= '0;
      awDone_q  <= 1'b0;
      wDone_q   <= 1'b0;
      rdata_q   <= '0;
      busErr_q  <= 1'b0;
    end else begin
      reqAddr_q <= reqAddr_d;
      reqMask_q <= reqMask_d;
      reqData_q <= reqData_d;
      awDone_q  <= awDone_d;
      wDone_q   <= wDone_d;
      rdata_q   <= rdata_d;
      busErr_q  <= busErr_d;
    end
  end

  // Next-state and channel control. AW and W are raised together but each
  // drops on its own handshake; WR_B is entered only once both have gone.
  // bus_err is a registered pulse, so it lines up with the first DONE cycle.
  always_comb begin
    state_d   = state_q;
    reqAddr_d = reqAddr_q;
    reqMask_d = reqMask_q;
    reqData_d = reqData_q;
    awDone_d  = awDone_q;
    wDone_d   = wDone_q;
    rdata_d   = rdata_q;
    busErr_d  = 1'b0;
    arvalid   = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    rready    = 1'b0;
    bready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_we_i || req_re_i) begin
          reqAddr_d = req_addr_i;
          reqMask_d = req_wmask_i;
          reqData_d = req_wdata_i;
          awDone_d  = 1'b0;
          wDone_d   = 1'b0;
          state_d   = req_we_i ? ST_WR_AWW : ST_RD_AR;
        end
      end
      ST_RD_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_d = ST_RD_R;
        end
      end
      ST_RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d  = rdata;
          busErr_d = (rresp != RESP_OKAY);
          state_d  = ST_DONE;
        end
      end
      ST_WR_AWW: begin
        awvalid  = !awDone_q;
        wvalid   = !wDone_q;
        awDone_d = awDone_q | awready;
        wDone_d  = wDone_q | wready;
        if (awDone_d && wDone_d) begin
          state_d = ST_WR_B;
        end
      end
      ST_WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          busErr_d = (bresp != RESP_OKAY);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (pipe_adv_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address/data channels are driven straight from the latched request
  always_comb begin
    araddr    = reqAddr_q & BEAT_MASK;
    awaddr    = reqAddr_q & BEAT_MASK;
    wdata     = reqData_q;
    wstrb     = reqMask_q;
    rdata_o   = rdata_q;
    bus_err_o = busErr_q;
    finish_o  = (state_q == ST_DONE);
  end

endmodule

// File: doc/mem_axi_dbridge.md
Name: mem_axi_dbridge

Overview:
- Data-side bus bridge directly downstream of the MEM stage.
- Consumes the MEM stage's request: data_addr, wmask, data, we, re.
- Drives one AXI4-Lite master transaction per request.
- Returns read data plus a completion flag, which the MEM stage uses to release mem_stall_req.

Parameters:
ADDR_W, 64, request/AXI address width
DATA_W, 64, data width (one beat)
STRB_W, DATA_W/8, write-strobe width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset (rst==0 resets on rising clk)
req_addr_i  in  ADDR_W  MEM-stage data address
req_wmask_i  in  STRB_W  byte write mask
req_wdata_i  in  DATA_W  lane-aligned store data
req_we_i  in  1  store request
req_re_i  in  1  load request
pipe_adv_i  in  1  MEM stage advances to next instruction this cycle
rdata_o  out  DATA_W  full 64-bit beat read (MEM stage selects lanes)
finish_o  out  1  request complete; rdata_o valid
bus_err_o  out  1  one-cycle pulse: non-OKAY RRESP/BRESP
awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AXI AW channel
wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/STRB_W/1/1  AXI W channel
bresp/bvalid/bready  in/in/out  2/1/1  AXI B channel
araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AXI AR channel
rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  AXI R channel

Behaviour:
- Reset (rst==0): state=IDLE; all valids/readies 0; rdata_o=0; finish_o=0; bus_err_o=0.
- Reset mid-transaction aborts to IDLE the same way; the AXI slave shares this reset.
- FSM states: IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE.
- IDLE:
  - req_we_i=1 -> WR_AWW. we has priority if we and re are both 1.
  - else req_re_i=1 -> RD_AR.
  - Address, mask and data are registered at this transition. Later changes to req_* are ignored until IDLE.
- Addresses: araddr/awaddr = {req_addr[ADDR_W-1:3],3'b000}, beat-aligned. wstrb=req_wmask, wdata=req_wdata. A zero mask is still issued.
- RD_AR:
  - arvalid=1, held stable until arready.
  - Handshake -> RD_R.
- RD_R:
  - rready=1.
  - On rvalid: capture rdata into rdata_o; bus_err_o=1 for that cycle if rresp!=2'b00; -> DONE.
- WR_AWW:
  - awvalid and wvalid asserted together. Each drops independently on its own handshake.
  - State moves to WR_B only once both handshakes have occurred, in the same or different cycles.
- WR_B:
  - bready=1.
  - On bvalid: bus_err_o per bresp; -> DONE.
  - rdata_o is unchanged by stores.
- DONE:
  - finish_o=1; rdata_o held.
  - Stays until pipe_adv_i=1, then -> IDLE. finish_o is 0 from the next cycle.
  - This prevents re-issuing the same store/load while the pipeline is frozen by another stall.
- Minimum latency with a zero-wait slave: request seen in IDLE at cycle 0; AR handshake at cycle 1; R at cycle 2; finish_o high at cycle 3.
- Back-to-back requests: a new request is sampled in IDLE on the cycle after pipe_adv_i. No request is issued while in DONE.
- pipe_adv_i in any state other than DONE is ignored.
- Errors do not alter the flow: the transaction still completes, and rdata_o takes the bus value.

Decomposition:
- Shared package holds:
  - state encoding (localparam 3-bit: IDLE=0, RD_AR=1, RD_R=2, WR_AWW=3, WR_B=4, DONE=5);
  - AXI resp constants OKAY=2'b00, SLVERR=2'b10;
  - width constants reused from the existing global defines.
- No sub-module: a single FSM plus a request register. The AW/W done flags are two local regs.

Test Plan:
- Load:
  - Stimulus: re=1, addr=0x8000_0013, slave returns rdata=0x1122334455667788 with zero waits.
  - Response: araddr=0x8000_0010; finish_o at cycle 3; rdata_o=0x1122334455667788; bus_err_o=0.
- Store, split W/AW:
  - Stimulus: we=1, addr=0x8000_0024, wmask=0xF0, wdata=0xDEADBEEF_00000000; wready arrives 2 cycles before awready.
  - Response: wvalid drops after its handshake while awvalid stays high; exactly one AW and one W; WR_B entered only after both; finish_o after bvalid.
- Frozen pipeline:
  - Stimulus: complete a store, then hold we=1 and pipe_adv_i=0 for 5 cycles.
  - Response: finish_o stays 1 and no second awvalid.
  - Then pipe_adv_i=1 with we=0: IDLE next cycle, finish_o=0.
- Error response:
  - Stimulus: slave returns rresp=2'b10 with rdata=0xAB.
  - Response: bus_err_o pulses exactly 1 cycle; rdata_o=0xAB; finish_o=1.
- Reset mid-operation:
  - Stimulus: rst=0 asserted while arvalid=1 with arready withheld.
  - Response: next edge arvalid=0, state IDLE, finish_o=0, rdata_o=0.
  - After release with re=1, a fresh AR is issued.
- Simultaneous we and re:
  - Stimulus: we=1 and re=1 together.
  - Response: write channel used, no arvalid.
